// File: rtl/ft245_tx_pkg.sv
// FT245 transmitter shared definitions: FSM state encoding, default frame flags
// and the sample-to-byte-count helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package ft245_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_FOOTER = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [7:0] DEF_START_FLAG = 8'hFF;
    localparam logic [7:0] DEF_STOP_FLAG  = 8'h8F;

    // Bytes needed to carry one sample of w bits.
    function automatic int nbytes(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; head_dat_o is valid whenever !empty_o.
// Latency: a push is visible at the head one cycle later. Backpressure: pushes
// while full are ignored unless a pop happens in the same cycle (pop frees the slot first).
// Ports: clk/rst (sync, active-high), push_i/push_dat_i, pop_i, head_dat_o, full_o, empty_o, count_o.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/ft245_tx.sv
// FT245 sync-FIFO transmitter: buffers samples, frames them (START, samples MSB-first, STOP).
// Latency: first START byte appears two cycles after the first sample is captured.
// Backpressure: TXE# high holds WR#/data; no backpressure to the sample source (drops set overflow).
// Ports: clk, rst (sync, active-high), en/din/din_valid (sample in), ft_txe_n (FT245 TXE#),
//        ft_wr_n/ft_data (FT245 write side), frame_done (pulse), overflow (sticky).
module ft245_tx
    import ft245_tx_pkg::*;
#(
    parameter int         DATA_WIDTH = 24,
    parameter int         FRAME_LEN  = 1024,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] START_FLAG = DEF_START_FLAG,
    parameter logic [7:0] STOP_FLAG  = DEF_STOP_FLAG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  ft_txe_n,
    output logic                  ft_wr_n,
    output logic [7:0]            ft_data,
    output logic                  frame_done,
    output logic                  overflow
);
    localparam int NBYTES = nbytes(DATA_WIDTH);
    localparam int SW     = NBYTES * 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int SCW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [SCW-1:0] LAST_SAMP = SCW'(FRAME_LEN - 1);

    state_e                state_q, state_d;
    logic                  wr_n_q, wr_n_d;
    logic [7:0]            data_q, data_d;
    logic [SW-1:0]         shift_q, shift_d;
    logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [SCW-1:0]        samp_cnt_q, samp_cnt_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overflow_q, overflow_d;

    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                  unused_fifo_count;
    logic [SW-1:0]         head_pad;
    logic                  xfer;
    logic                  load;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (en && din_valid),
        .push_dat_i (din),
        .pop_i      (fifo_pop),
        .head_dat_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign unused_fifo_count = ^fifo_count;

    // Zero-extend so unused top bits of the first byte go out as zero.
    assign head_pad = SW'(fifo_head);
    assign xfer     = !wr_n_q && !ft_txe_n;

    always_comb begin
        state_d      = state_q;
        wr_n_d       = wr_n_q;
        data_d       = data_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        frame_done_d = 1'b0;
        load         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_HEADER;
                    wr_n_d  = 1'b0;
                    data_d  = START_FLAG;
                end
            end
            ST_HEADER: begin
                // FIFO cannot have drained since IDLE saw it non-empty.
                if (xfer) begin
                    state_d = ST_DATA;
                    load    = 1'b1;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    if (byte_cnt_q != LAST_BYTE) begin
                        data_d     = shift_q[SW-1 -: 8];
                        shift_d    = shift_q << 8;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end else if (samp_cnt_q == LAST_SAMP) begin
                        state_d = ST_FOOTER;
                        data_d  = STOP_FLAG;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                        if (!fifo_empty) load = 1'b1;
                        else             wr_n_d = 1'b1;
                    end
                end else if (wr_n_q && !fifo_empty) begin
                    // Starved mid-frame: resume as soon as a sample lands.
                    load = 1'b1;
                end
            end
            ST_FOOTER: begin
                if (xfer) begin
                    state_d      = ST_DONE;
                    wr_n_d       = 1'b1;
                    frame_done_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                samp_cnt_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Pop the head sample, present its MSB byte, keep the rest for shifting.
        if (load) begin
            wr_n_d     = 1'b0;
            data_d     = head_pad[SW-1 -: 8];
            shift_d    = head_pad << 8;
            byte_cnt_d = '0;
        end
    end

    assign fifo_pop   = load;
    // A pop in the same cycle frees the slot, so the push is not a drop.
    assign overflow_d = overflow_q | (en && din_valid && fifo_full && !fifo_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_n_q       <= 1'b1;
            data_q       <= '0;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            samp_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_n_q       <= wr_n_d;
            data_q       <= data_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign ft_wr_n    = wr_n_q;
    assign ft_data    = data_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ft245_tx.sv
// Bench for ft245_tx with FRAME_LEN=4, DATA_WIDTH=24, FIFO_DEPTH=16.
// Expected bytes are queued by the stimulus; a negedge monitor pops one per transfer.
// Ports of the DUT are driven #1 after the rising edge.
module tb_ft245_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] din;
    logic        din_valid;
    logic        ft_txe_n;
    logic        ft_wr_n;
    logic [7:0]  ft_data;
    logic        frame_done;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int low_cnt  = 0;
    int run_cnt  = 0;
    int max_run  = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    ft245_tx #(
        .DATA_WIDTH (24),
        .FRAME_LEN  (4),
        .FIFO_DEPTH (16),
        .START_FLAG (8'hFF),
        .STOP_FLAG  (8'h8F)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .din_valid  (din_valid),
        .ft_txe_n   (ft_txe_n),
        .ft_wr_n    (ft_wr_n),
        .ft_data    (ft_data),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Scoreboard monitor: inputs are stable here, so this sees what the next edge transfers.
    always @(negedge clk) begin
        logic [7:0] e;
        if (ft_wr_n === 1'b0) begin
            low_cnt++;
            run_cnt++;
            if (run_cnt > max_run) max_run = run_cnt;
        end else begin
            run_cnt = 0;
        end
        if (ft_wr_n === 1'b0 && ft_txe_n === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_byte: got %02h, required no transfer", ft_data);
            end else begin
                e = exp_q.pop_front();
                check("stream_byte", {24'b0, ft_data}, {24'b0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        low_cnt = 0;
        run_cnt = 0;
        max_run = 0;
    endtask

    task automatic push_sample(input logic [23:0] s);
        en        = 1'b1;
        din_valid = 1'b1;
        din       = s;
        tick();
        en        = 1'b0;
        din_valid = 1'b0;
        din       = '0;
    endtask

    task automatic expect_sample(input logic [23:0] s);
        exp_q.push_back(s[23:16]);
        exp_q.push_back(s[15:8]);
        exp_q.push_back(s[7:0]);
    endtask

    task automatic expect_frame(input logic [23:0] a, input logic [23:0] b,
                                input logic [23:0] c, input logic [23:0] d);
        exp_q.push_back(8'hFF);
        expect_sample(a);
        expect_sample(b);
        expect_sample(c);
        expect_sample(d);
        exp_q.push_back(8'h8F);
    endtask

    task automatic send_frame(input logic [23:0] a, input logic [23:0] b,
                              input logic [23:0] c, input logic [23:0] d);
        en = 1'b1; din_valid = 1'b1;
        din = a; tick();
        din = b; tick();
        din = c; tick();
        din = d; tick();
        en = 1'b0; din_valid = 1'b0; din = '0;
    endtask

    // Waits for nframes frame_done pulses, then confirms the last pulse is one cycle wide.
    task automatic wait_frames(input string name, input int nframes, input int budget);
        int seen;
        seen = 0;
        for (int c = 0; c < budget && seen < nframes; c++) begin
            tick();
            if (frame_done === 1'b1) seen++;
        end
        check({name, "_frames_seen"}, seen, nframes);
        tick();
        check({name, "_done_width"}, {31'b0, frame_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;

        // 1: reset with random inputs
        rst = 1'b1; en = 1'b0; din = '0; din_valid = 1'b0; ft_txe_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            en        = 1'($urandom);
            din_valid = 1'($urandom);
            din       = 24'($urandom);
            ft_txe_n  = 1'($urandom);
            tick();
            check("rst_wr_n",       {31'b0, ft_wr_n},    32'd1);
            check("rst_data",       {24'b0, ft_data},    32'd0);
            check("rst_frame_done", {31'b0, frame_done}, 32'd0);
            check("rst_overflow",   {31'b0, overflow},   32'd0);
        end
        en = 1'b0; din_valid = 1'b0; din = '0; ft_txe_n = 1'b0;
        rst = 1'b0;
        tick();
        check("post_rst_wr_n", {31'b0, ft_wr_n}, 32'd1);
        tick();
        check("post_rst_wr_n_idle", {31'b0, ft_wr_n}, 32'd1);

        // 2: basic frame, 14 contiguous write cycles
        clear_counts();
        expect_frame(24'h123456, 24'hABCDEF, 24'h000001, 24'hFFFFFF);
        send_frame(24'h123456, 24'hABCDEF, 24'h000001, 24'hFFFFFF);
        wait_frames("basic", 1, 60);
        check("basic_low_cycles", low_cnt, 14);
        check("basic_max_run",    max_run, 14);
        check("basic_queue_empty", exp_q.size(), 0);

        // 3: stall 5 cycles while 0xCD is presented
        clear_counts();
        expect_frame(24'h123456, 24'hABCDEF, 24'h000001, 24'hFFFFFF);
        send_frame(24'h123456, 24'hABCDEF, 24'h000001, 24'hFFFFFF);
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            if (ft_wr_n === 1'b0 && ft_data === 8'hCD) found = 1;
            else tick();
        end
        check("stall_found_cd", found, 1);
        ft_txe_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_data", {24'b0, ft_data}, 32'hCD);
            check("stall_wr_n", {31'b0, ft_wr_n}, 32'd0);
        end
        ft_txe_n = 1'b0;
        wait_frames("stall", 1, 60);
        check("stall_low_cycles", low_cnt, 19);
        check("stall_max_run",    max_run, 19);
        check("stall_queue_empty", exp_q.size(), 0);

        // 4: overflow on the 17th sample with TXE# high
        ft_txe_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            push_sample(24'(i));
            if (i == 16) check("ovf_before_17", {31'b0, overflow}, 32'd0);
            if (i == 17) check("ovf_at_17",     {31'b0, overflow}, 32'd1);
        end
        for (int f = 0; f < 4; f++)
            expect_frame(24'(4*f+1), 24'(4*f+2), 24'(4*f+3), 24'(4*f+4));
        clear_counts();
        ft_txe_n = 1'b0;
        wait_frames("ovf", 4, 200);
        check("ovf_low_cycles",  low_cnt, 56);
        check("ovf_max_run",     max_run, 14);
        check("ovf_queue_empty", exp_q.size(), 0);
        check("ovf_sticky",      {31'b0, overflow}, 32'd1);

        // 5: enable gating
        clear_counts();
        en = 1'b0; din_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = 24'(i + 24'h5A0000);
            tick();
            check("gate_wr_n", {31'b0, ft_wr_n}, 32'd1);
        end
        din_valid = 1'b0;
        tick(); tick(); tick();
        check("gate_no_writes", low_cnt, 0);

        // 6: reset mid-frame
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h11);
        send_frame(24'h111111, 24'h222222, 24'h333333, 24'h444444);
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            if (ft_wr_n === 1'b0 && ft_data === 8'h22) found = 1;
            else tick();
        end
        check("midrst_found_22", found, 1);
        rst = 1'b1; ft_txe_n = 1'b1;
        tick();
        check("midrst_wr_n",     {31'b0, ft_wr_n},  32'd1);
        check("midrst_data",     {24'b0, ft_data},  32'd0);
        check("midrst_overflow", {31'b0, overflow}, 32'd0);
        rst = 1'b0; ft_txe_n = 1'b0;
        clear_counts();
        for (int i = 0; i < 5; i++) tick();
        check("midrst_flushed",     low_cnt, 0);
        check("midrst_queue_empty", exp_q.size(), 0);
        clear_counts();
        expect_frame(24'h0A0B0C, 24'h102030, 24'h000000, 24'h800000);
        send_frame(24'h0A0B0C, 24'h102030, 24'h000000, 24'h800000);
        wait_frames("midrst", 1, 60);
        check("midrst_low_cycles",  low_cnt, 14);
        check("midrst_queue_final", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
